// File: rtl/param_config_multiplier.sv
// param_config_multiplier
//   Iterative two's-complement multiplier with four modes. The datapath does one
//   shift-add step per clock and has valid/ready handshakes on both sides.
//   Modes (mode_i, latched at accept):
//     00  single lane  : A[L-1:0]*B[L-1:0], signed, sign-extended to 2*WIDTH
//     01  dual lane    : two independent signed LxL products in the WIDTH halves
//     10  full signed  : WIDTH x WIDTH
//     11  full unsigned: WIDTH x WIDTH
//   Ports:
//     clk_i, reset_i                  clock; synchronous active-high reset
//     in_valid_i / in_ready_o         operand handshake (ready only in IDLE)
//     mode_i, multiplicand_i (A),
//     multiplier_i (B)                operands, sampled at accept only
//     out_valid_o / out_ready_i       product handshake (valid only in DONE)
//     product_o                       2*WIDTH result, held stable in DONE
//     busy_o                          high while iterating
module param_config_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [1:0]           mode_i,
  input  logic [WIDTH-1:0]     multiplicand_i,
  input  logic [WIDTH-1:0]     multiplier_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 busy_o
);

  localparam int L  = WIDTH / 2;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_N_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] C_N_LANE = CW'(L);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_mode;
  logic [2*WIDTH-1:0]   r_mcand;    // single-path multiplicand, shifted left per step
  logic [WIDTH-1:0]     r_lane_lo;  // dual-lane multiplicands, shifted left per step
  logic [WIDTH-1:0]     r_lane_hi;
  logic [WIDTH-1:0]     r_mplier;   // shifted right per step
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;

  logic                 w_accept;
  logic                 w_stepping;
  logic                 w_last;
  logic                 w_sub;
  logic [CW-1:0]        w_steps;
  logic [2*WIDTH-1:0]   w_pp;
  logic [2*WIDTH-1:0]   w_acc_full;
  logic [WIDTH-1:0]     w_pp_lo;
  logic [WIDTH-1:0]     w_pp_hi;
  logic [WIDTH-1:0]     w_acc_lo;
  logic [WIDTH-1:0]     w_acc_hi;
  logic [2*WIDTH-1:0]   w_acc_nxt;

  assign w_accept   = in_valid_i && (r_state == S_IDLE);
  assign w_steps    = r_mode[1] ? C_N_FULL : C_N_LANE;
  // BUSY spends N cycles stepping plus one settle cycle (r_cnt == N) before DONE.
  assign w_stepping = (r_state == S_BUSY) && (r_cnt != w_steps);
  assign w_last     = (r_cnt == (w_steps - 1'b1));
  // The sign bit of a signed multiplier carries negative weight, so its
  // partial product is subtracted instead of added.
  assign w_sub      = w_last && (r_mode != 2'b11);

  assign w_pp       = r_mplier[0] ? r_mcand : '0;
  assign w_acc_full = w_sub ? (r_acc - w_pp) : (r_acc + w_pp);

  // The upper lane's multiplier bits sit at r_mplier[L] as r_mplier shifts right.
  assign w_pp_lo    = r_mplier[0] ? r_lane_lo : '0;
  assign w_pp_hi    = r_mplier[L] ? r_lane_hi : '0;
  assign w_acc_lo   = w_sub ? (r_acc[WIDTH-1:0] - w_pp_lo)
                            : (r_acc[WIDTH-1:0] + w_pp_lo);
  assign w_acc_hi   = w_sub ? (r_acc[2*WIDTH-1:WIDTH] - w_pp_hi)
                            : (r_acc[2*WIDTH-1:WIDTH] + w_pp_hi);

  assign w_acc_nxt  = (r_mode == 2'b01) ? {w_acc_hi, w_acc_lo} : w_acc_full;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        busy_o = 1'b1;
        if (r_cnt == w_steps) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_mode    <= '0;
      r_mcand   <= '0;
      r_lane_lo <= '0;
      r_lane_hi <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
    end else if (w_accept) begin
      r_mode    <= mode_i;
      r_mplier  <= multiplier_i;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_lane_lo <= {{(WIDTH-L){multiplicand_i[L-1]}}, multiplicand_i[L-1:0]};
      r_lane_hi <= {{(WIDTH-L){multiplicand_i[WIDTH-1]}}, multiplicand_i[WIDTH-1:L]};
      unique case (mode_i)
        2'b00:   r_mcand <= {{(2*WIDTH-L){multiplicand_i[L-1]}}, multiplicand_i[L-1:0]};
        2'b10:   r_mcand <= {{WIDTH{multiplicand_i[WIDTH-1]}}, multiplicand_i};
        default: r_mcand <= {{WIDTH{1'b0}}, multiplicand_i};
      endcase
    end else if (w_stepping) begin
      r_acc     <= w_acc_nxt;
      r_mcand   <= r_mcand << 1;
      r_lane_lo <= r_lane_lo << 1;
      r_lane_hi <= r_lane_hi << 1;
      r_mplier  <= r_mplier >> 1;
      r_cnt     <= r_cnt + 1'b1;
    end
  end

  assign product_o = r_acc;

endmodule

// File: tb/tb_param_config_multiplier.sv
module tb_param_config_multiplier;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [1:0]    mode_i;
  logic [W-1:0]  multiplicand_i;
  logic [W-1:0]  multiplier_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [2*W-1:0] product_o;
  logic          busy_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  param_config_multiplier #(.WIDTH(W)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .mode_i         (mode_i),
    .multiplicand_i (multiplicand_i),
    .multiplier_i   (multiplier_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .product_o      (product_o),
    .busy_o         (busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference products computed directly from the arithmetic definition.
  function automatic logic [31:0] model(input logic [1:0] m, input logic [15:0] a,
                                        input logic [15:0] b);
    int ia, ib, ja, jb, p, q;
    longint unsigned ua, ub, up;
    logic [31:0] r;
    case (m)
      2'b00: begin
        ia = $signed(a[7:0]); ib = $signed(b[7:0]); p = ia * ib; r = p;
      end
      2'b01: begin
        ia = $signed(a[7:0]);  ib = $signed(b[7:0]);  p = ia * ib;
        ja = $signed(a[15:8]); jb = $signed(b[15:8]); q = ja * jb;
        r = {q[15:0], p[15:0]};
      end
      2'b10: begin
        ia = $signed(a); ib = $signed(b); p = ia * ib; r = p;
      end
      default: begin
        ua = a; ub = b; up = ua * ub; r = up[31:0];
      end
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input logic [1:0] m);
    return m[1] ? W + 1 : W / 2 + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one op, measure latency, check product, complete handshake.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [15:0] a,
                        input logic [15:0] b);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready_o && guard < 100) begin step(); guard++; end
    if (!in_ready_o) chk({tag, "_idle_timeout"}, 0, 1);
    in_valid_i = 1'b1; mode_i = m; multiplicand_i = a; multiplier_i = b;
    step();
    in_valid_i = 1'b0;
    mode_i = 2'($urandom); multiplicand_i = 16'($urandom); multiplier_i = 16'($urandom);
    lat = 0;
    while (!out_valid_o && lat < 100) begin
      step(); lat++;
      mode_i = 2'($urandom); multiplicand_i = 16'($urandom); multiplier_i = 16'($urandom);
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_latency(m)));
    chk({tag, "_product"}, 64'(product_o), 64'(model(m, a, b)));
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    chk({tag, "_ready_after"}, 64'(in_ready_o), 64'd1);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] held;
    int accepted, popped, cycles;

    reset_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    mode_i = '0; multiplicand_i = '0; multiplier_i = '0;
    step(); step();
    reset_i = 1'b0;
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_product", 64'(product_o), 64'd0);

    run_op("t1_m10", 2'b10, 16'h5527, 16'h8000);
    chk("t1_const", 64'(model(2'b10, 16'h5527, 16'h8000)), 64'hD56C8000);
    run_op("t2_m01", 2'b01, 16'h7F80, 16'h80FF);
    run_op("t3_m00", 2'b00, 16'h00FD, 16'h0005);
    run_op("t3_m11", 2'b11, 16'hFFFF, 16'hFFFF);
    run_op("mn_m00", 2'b00, 16'h0080, 16'h0080);
    run_op("mn_m01", 2'b01, 16'h8080, 16'h8080);
    run_op("mn_m10", 2'b10, 16'h8000, 16'h8000);
    run_op("zero_m10", 2'b10, 16'h0000, 16'h0000);
    run_op("zero_m01", 2'b01, 16'h0000, 16'h1234);

    // Backpressure in DONE with new operands offered.
    in_valid_i = 1'b1; mode_i = 2'b10; multiplicand_i = 16'h1234; multiplier_i = 16'hFEDC;
    step();
    in_valid_i = 1'b0;
    cycles = 0;
    while (!out_valid_o && cycles < 100) begin step(); cycles++; end
    held = model(2'b10, 16'h1234, 16'hFEDC);
    in_valid_i = 1'b1; mode_i = 2'b11; multiplicand_i = 16'h7777; multiplier_i = 16'h3333;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 64'(out_valid_o), 64'd1);
      chk("bp_product", 64'(product_o), 64'(held));
      chk("bp_in_ready", 64'(in_ready_o), 64'd0);
    end
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    chk("bp_busy_after", 64'(busy_o), 64'd0);
    chk("bp_idle_after", 64'(in_ready_o), 64'd1);
    in_valid_i = 1'b0;

    // Reset during the 4th BUSY cycle.
    in_valid_i = 1'b1; mode_i = 2'b10; multiplicand_i = 16'h4321; multiplier_i = 16'h1111;
    step();
    in_valid_i = 1'b0;
    step(); step(); step();
    chk("rst_mid_busy_pre", 64'(busy_o), 64'd1);
    reset_i = 1'b1;
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    step();
    reset_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    chk("rst_mid_in_ready", 64'(in_ready_o), 64'd1);
    chk("rst_mid_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_mid_busy", 64'(busy_o), 64'd0);
    chk("rst_mid_product", 64'(product_o), 64'd0);
    run_op("after_rst", 2'b01, 16'h9C3A, 16'h5AF1);

    // Random traffic with random backpressure, scoreboard in a queue.
    accepted = 0; popped = 0; cycles = 0;
    while ((accepted < 200 || q.size() != 0) && cycles < 20000) begin
      in_valid_i     = (accepted < 200) && ($urandom_range(0, 3) != 0);
      mode_i         = 2'($urandom);
      multiplicand_i = 16'($urandom);
      multiplier_i   = 16'($urandom);
      out_ready_i    = ($urandom_range(0, 2) != 0);
      if (in_valid_i && in_ready_o) begin
        q.push_back(model(mode_i, multiplicand_i, multiplier_i));
        accepted++;
      end
      if (out_valid_o && out_ready_i) begin
        if (q.size() == 0) chk("rnd_spurious", 64'd1, 64'd0);
        else chk("rnd_product", 64'(product_o), 64'(q.pop_front()));
        popped++;
      end
      step();
      cycles++;
    end
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    chk("rnd_accepted", 64'(accepted), 64'd200);
    chk("rnd_popped", 64'(popped), 64'd200);
    chk("rnd_queue_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
